// File: rtl/inst_mem.sv
// Instruction memory responder for the fetch stage: word-addressed read with
// programmable latency, plus an independent word-wide preload port.
module inst_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_req,
  output logic [31:0] mem_dat_out,
  output logic        mem_vld,
  output logic        mem_busy,
  output logic        mem_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_dat
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 2;
  localparam int unsigned CNT_INIT = (LAT > 1) ? LAT - 2 : 0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q;
  logic            capture;
  logic            resp;
  logic [31:0]     rd_addr;
  logic [AW-1:0]   rd_idx;
  logic            rd_err;
  logic [31:0]     mem [DEPTH];

  // Load port bits that do not reach the array index.
  logic unused_ld;
  assign unused_ld = ^{ld_addr[31:AW+2], ld_addr[1:0]};

  // Storage: not reset, so program contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr[AW+1:2]] <= ld_dat;
  end

  // With LAT=1 the response uses the address presented at the accept edge.
  assign rd_addr = (LAT == 1) ? mem_addr : addr_q;
  assign rd_idx  = rd_addr[AW+1:2];
  assign rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= 30'(DEPTH));

  // Next-state and response decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (LAT == 1) begin
            resp = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = WAIT;
            cnt_d   = CW'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; array read returns pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_vld     <= 1'b0;
      mem_busy    <= 1'b0;
      mem_err     <= 1'b0;
      mem_dat_out <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_vld  <= resp;
      mem_busy <= (state_d == WAIT);
      if (capture) addr_q <= mem_addr;
      if (resp) begin
        mem_err     <= rd_err;
        mem_dat_out <= rd_err ? NOP : mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: three instances (LAT 1, 3, 4) share one stimulus.
module tb_inst_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_dat;

  logic [31:0] dat1, dat3, dat4;
  logic        vld1, vld3, vld4;
  logic        busy1, busy3, busy4;
  logic        err1, err3, err4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_mem #(.DEPTH(1024), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_dat_out(dat1), .mem_vld(vld1), .mem_busy(busy1), .mem_err(err1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_dat(ld_dat));

  inst_mem #(.DEPTH(1024), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_dat_out(dat3), .mem_vld(vld3), .mem_busy(busy3), .mem_err(err3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_dat(ld_dat));

  inst_mem #(.DEPTH(1024), .LAT(4)) u4 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_dat_out(dat4), .mem_vld(vld4), .mem_busy(busy4), .mem_err(err4),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_dat(ld_dat));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_dat = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_addr = '0; mem_req = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
    tick(); tick();
    chk("rst_vld1", 32'(vld1), 0);
    chk("rst_dat1", dat1, 0);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_err4", 32'(err4), 0);
    rst = 1'b0;

    load(32'h10, 32'hDEAD_BEEF);
    load(32'h0, 32'h1);
    load(32'h4, 32'h2);
    load(32'h8, 32'h3);
    load(32'h20, 32'h11);

    // LAT=1 basic read
    mem_addr = 32'h10; mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    chk("l1_vld", 32'(vld1), 1);
    chk("l1_dat", dat1, 32'hDEAD_BEEF);
    chk("l1_err", 32'(err1), 0);
    chk("l1_busy", 32'(busy1), 0);
    tick();
    chk("l1_vld_pulse", 32'(vld1), 0);
    chk("l1_busy_after", 32'(busy1), 0);
    repeat (5) tick();

    // LAT=3 requests every cycle; middle one is dropped
    mem_req = 1'b1; mem_addr = 32'h0;
    tick();
    chk("l3_busy_e0", 32'(busy3), 1);
    chk("l3_vld_e0", 32'(vld3), 0);
    mem_addr = 32'h4;
    tick();
    chk("l3_vld_e1", 32'(vld3), 0);
    mem_addr = 32'h8;
    tick();
    chk("l3_vld_e2", 32'(vld3), 1);
    chk("l3_dat_e2", dat3, 32'h1);
    chk("l3_busy_e2", 32'(busy3), 0);
    tick();
    mem_req = 1'b0;
    chk("l3_vld_e3", 32'(vld3), 0);
    chk("l3_busy_e3", 32'(busy3), 1);
    tick();
    chk("l3_vld_e4", 32'(vld3), 0);
    tick();
    chk("l3_vld_e5", 32'(vld3), 1);
    chk("l3_dat_e5", dat3, 32'h3);
    repeat (5) tick();

    // Error responses on LAT=1, then a good read clears mem_err
    mem_req = 1'b1; mem_addr = 32'h6;
    tick();
    chk("err_mis_vld", 32'(vld1), 1);
    chk("err_mis_dat", dat1, 32'h13);
    chk("err_mis_err", 32'(err1), 1);
    mem_addr = 32'h1000;
    tick();
    chk("err_oob_vld", 32'(vld1), 1);
    chk("err_oob_dat", dat1, 32'h13);
    chk("err_oob_err", 32'(err1), 1);
    mem_addr = 32'h10;
    tick();
    chk("err_clr_err", 32'(err1), 0);
    chk("err_clr_dat", dat1, 32'hDEAD_BEEF);

    // Load and read of the same word on the same edge
    mem_addr = 32'h20;
    ld_en = 1'b1; ld_addr = 32'h20; ld_dat = 32'h55;
    tick();
    ld_en = 1'b0;
    chk("rw_old", dat1, 32'h11);
    tick();
    chk("rw_new", dat1, 32'h55);
    mem_req = 1'b0;
    repeat (6) tick();
    chk("pre_rst_dat4_nz", 32'(dat4 != 0), 1);

    // LAT=4 request killed by reset two cycles after acceptance
    mem_req = 1'b1; mem_addr = 32'h4;
    tick();
    mem_req = 1'b0;
    chk("l4_busy_e0", 32'(busy4), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("l4_rst_vld", 32'(vld4), 0);
    chk("l4_rst_busy", 32'(busy4), 0);
    chk("l4_rst_err", 32'(err4), 0);
    chk("l4_rst_dat", dat4, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l4_no_vld", 32'(vld4), 0);
    end
    mem_req = 1'b1; mem_addr = 32'h4;
    tick();
    mem_req = 1'b0;
    tick(); tick();
    chk("l4_vld_e2", 32'(vld4), 0);
    tick();
    chk("l4_vld_e3", 32'(vld4), 1);
    chk("l4_dat_e3", dat4, 32'h2);
    chk("l4_err_e3", 32'(err4), 0);

    // Load address wraps on upper bits
    load(32'h1000_0004, 32'hCAFE_F00D);
    mem_req = 1'b1; mem_addr = 32'h4;
    tick();
    mem_req = 1'b0;
    chk("wrap_dat", dat1, 32'hCAFE_F00D);
    chk("wrap_err", 32'(err1), 0);
    mem_req = 1'b1; mem_addr = 32'h0;
    tick();
    mem_req = 1'b0;
    chk("wrap_w0_intact", dat1, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
